// File: rtl/router_output_port.sv
// router_output_port: per-port packet FIFO feeding a 4-byte MSB-first serializer onto the byte link.
module router_output_port #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_avail,
  output logic        ready_to_recv,
  input  logic        free_outbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound,
  output logic [7:0]  drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, next_state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [31:0] shift_reg;
  logic [1:0] byte_idx;
  logic push, pop, drop;
  // Ready comes only from registered count, so a same-cycle pop never frees a full FIFO.
  assign ready_to_recv = count != (AW+1)'(DEPTH);
  assign push = pkt_in_avail && ready_to_recv;
  assign drop = pkt_in_avail && !ready_to_recv && drop_count != 8'hFF;
  always_comb begin
    next_state = state;
    pop = 1'b0;
    put_outbound = 1'b0;
    payload_outbound = 8'h00;
    if (state == IDLE) begin
      pop = count != '0 && free_outbound;
      next_state = pop ? SEND : IDLE;
    end else begin
      put_outbound = 1'b1;
      payload_outbound = shift_reg[31:24];
      next_state = byte_idx == 2'd3 ? IDLE : SEND;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      head <= '0;
      tail <= '0;
      shift_reg <= '0;
      byte_idx <= '0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) tail <= tail + AW'(1);
      if (pop) begin
        head <= head + AW'(1);
        shift_reg <= mem[head];
        byte_idx <= 2'd0;
      end else if (state == SEND) begin
        shift_reg <= shift_reg << 8;
        byte_idx <= byte_idx + 2'd1;
      end
      if (drop) drop_count <= drop_count + 8'd1;
    end
  always_ff @(posedge clock)
    if (push) mem[tail] <= pkt_in;
endmodule

// File: tb/tb_router_output_port.sv
// tb_router_output_port: random and directed stimulus checked against a queue-based packet/byte model.
module tb_router_output_port;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] pkt_in = '0;
  logic pkt_in_avail = 1'b0;
  logic free_outbound = 1'b0;
  logic ready_to_recv, put_outbound;
  logic [7:0] payload_outbound, drop_count;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] fq[$];
  logic [7:0] cur[$];
  int drops = 0;

  router_output_port #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
    .ready_to_recv(ready_to_recv), .free_outbound(free_outbound), .put_outbound(put_outbound),
    .payload_outbound(payload_outbound), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    fq.delete();
    cur.delete();
    drops = 0;
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance both across the edge.
  task automatic cyc(input logic a, input logic [31:0] p, input logic f);
    logic push, start;
    logic [31:0] w;
    check("ready", 32'(ready_to_recv), 32'(fq.size() < DEPTH));
    check("put", 32'(put_outbound), 32'(cur.size() > 0));
    check("byte", 32'(payload_outbound), 32'(cur.size() > 0 ? cur[0] : 8'h00));
    check("drops", 32'(drop_count), 32'(drops));
    check("count", 32'(dut.count), 32'(fq.size()));
    pkt_in_avail = a;
    pkt_in = p;
    free_outbound = f;
    push = a && fq.size() < DEPTH;
    start = cur.size() == 0 && fq.size() > 0 && f;
    @(posedge clock);
    #1;
    if (a && !push && drops < 255) drops++;
    if (cur.size() > 0) void'(cur.pop_front());
    else if (start) begin
      w = fq.pop_front();
      for (int i = 3; i >= 0; i--) cur.push_back(w[8*i +: 8]);
    end
    if (push) fq.push_back(p);
  endtask

  task automatic do_reset();
    pkt_in_avail = 1'b0;
    free_outbound = 1'b0;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("rst_ready", 32'(ready_to_recv), 32'd1);
    check("rst_put", 32'(put_outbound), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
  endtask

  task automatic mid_reset();
    pkt_in_avail = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_put", 32'(put_outbound), 32'd0);
    check("async_byte", 32'(payload_outbound), 32'd0);
    check("async_ready", 32'(ready_to_recv), 32'd1);
    check("async_drops", 32'(drop_count), 32'd0);
    check("async_count", 32'(dut.count), 32'd0);
    model_clear();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    cyc(1'b1, 32'h1234_5678, 1'b1);
    repeat (7) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hA0A0_0000 + 32'(i), 1'b0);
    check("fill_drop", 32'(drop_count), 32'd1);
    repeat (25) cyc(1'b0, '0, 1'b1);
    do_reset();
    repeat (304) cyc(1'b1, $urandom, 1'b0);
    check("sat", 32'(drop_count), 32'hFF);
    repeat (5) cyc(1'b1, $urandom, 1'b0);
    repeat (25) cyc(1'b0, '0, 1'b1);
    do_reset();
    cyc(1'b1, 32'hB000_0001, 1'b0);
    cyc(1'b1, 32'hB000_0002, 1'b0);
    for (int i = 0; i < 60; i++) cyc(i % 5 == 0, 32'hC000_0000 + 32'(i), 1'b1);
    repeat (20) cyc(1'b0, '0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hD000_0000 + 32'(i), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    mid_reset();
    cyc(1'b1, 32'hCAFE_BABE, 1'b1);
    repeat (7) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 500; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 9) < 7);
    repeat (30) cyc(1'b0, '0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/router_output_port.md
# router_output_port

Per-output-port buffering and serialization stage that sits directly downstream of the router's four-way routing/arbitration logic. It accepts at most one 32-bit `pkt_t` per cycle from the arbiter, holds up to `DEPTH` packets in a FIFO, and drives `ready_to_recv` back to the arbiter. It transmits each packet to the neighbouring node over an 8-bit byte link with a `free_outbound`/`put_outbound` handshake. The router instantiates one copy per port (0–3).

## Interface
- `DEPTH`, default 4: FIFO capacity in packets; must be a power of two and at least 2.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `pkt_in` input 32 (`pkt_t`): packet from the arbiter, laid out as {src[31:28], dest[27:24], data[23:0]}.
- `pkt_in_avail` input 1: `pkt_in` is valid this cycle.
- `ready_to_recv` output 1: FIFO can accept a packet this cycle.
- `free_outbound` input 1: the downstream node can take a new packet.
- `put_outbound` output 1: a byte is valid on `payload_outbound` this cycle.
- `payload_outbound` output 8: link byte, most significant byte first.
- `drop_count` output 8: saturating count of packets offered while the FIFO was full.

## Operation
- **Write.** A push occurs when `pkt_in_avail && ready_to_recv`. `pkt_in` is written at the tail and `count` increments.
- **Ready.** `ready_to_recv = (count != DEPTH)`.
  - It is driven from registered `count` only, so there is no combinational path from `free_outbound` or `pkt_in_avail`.
  - A pop in the same cycle does not open a slot when the FIFO is full.
- **Drops.** If `pkt_in_avail` is high while the FIFO is full, the packet is discarded and `drop_count` increments. The counter holds at 8'hFF.
- **State machine.** Two states: `IDLE` and `SEND`. The byte index `byte_idx` is 2 bits.
  - `IDLE` → `SEND` when `count != 0 && free_outbound`. On that edge: load `shift_reg` with the FIFO head, pop the head (count−1, head+1), and set `byte_idx = 0`.
  - In `SEND`: `put_outbound = 1` and `payload_outbound = shift_reg[31:24]`. Each edge shifts `shift_reg` left by 8 and increments `byte_idx`.
  - `SEND` → `IDLE` on the edge where `byte_idx == 3`.
  - `free_outbound` is sampled only in `IDLE`. Once a packet starts, all 4 bytes go out unconditionally.
  - In `IDLE`: `put_outbound = 0` and `payload_outbound = 8'h00`.
- **Simultaneous push and pop.** Both take effect on the same edge and `count` is unchanged.
  - When `count == 0`, a push in the same cycle is not popped; the earliest start is the next edge.
- **Pointers.** Head and tail pointers are `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`.
- **Count.** `count` is `$clog2(DEPTH)+1` bits and never exceeds `DEPTH` or goes below 0.

## Timing
- **Reset (asynchronous, `reset_n` = 0).** Reset forces:
  - state = `IDLE`; `count`, head, tail, `shift_reg` and `byte_idx` = 0;
  - `drop_count` = 0, `put_outbound` = 0, `payload_outbound` = 0;
  - `ready_to_recv` = 1 (because `count == 0`).
- **Reset mid-`SEND`.** The partial packet and all FIFO contents are lost. Outputs go to their reset values immediately, not at the next edge.
- **Latency.** A packet pushed at edge N, into an empty idle port with `free_outbound` = 1:
  - at edge N+1: `SEND` is entered;
  - cycles N+1 through N+4: the four bytes are on the link;
  - at edge N+5: the port is back in `IDLE`.
- **Throughput.** The minimum packet-to-packet interval is 5 cycles (4 bytes plus 1 `IDLE` cycle). There are no back-to-back packets.
- **Handshake.** `put_outbound` stays high for exactly 4 consecutive cycles per packet and is never high in `IDLE`.
- **Ordering.** Packets leave strictly in push order.

## Test plan
- **Reset.** Hold `reset_n` = 0 for 2 cycles, then release. Required: `ready_to_recv` = 1, `put_outbound` = 0, `drop_count` = 0. Assert `reset_n` low mid-cycle: outputs clear without waiting for a clock edge.
- **Single packet.** Push 32'h1234_5678 with `free_outbound` = 1. Required: the bytes 12, 34, 56, 78 appear on consecutive cycles starting 1 cycle after the push, `put_outbound` is high for exactly those 4 cycles, then `IDLE`.
- **Fill and drop.** With `free_outbound` = 0, push 5 packets (A0..A4). Required: `ready_to_recv` = 0 after the 4th push, A4 is dropped, `drop_count` = 1. Then raise `free_outbound`: A0..A3 are emitted in order at 5-cycle spacing.
- **Saturation.** Offer 300 packets to a full FIFO. Required: `drop_count` = 8'hFF and it holds there.
- **Simultaneous push and pop.** With `count` = 2, hold `free_outbound` = 1 and push on the `IDLE`→`SEND` edge. Required: `count` stays 2 and the pointers wrap correctly across 10 or more packets, with no reordering or loss.
- **Reset mid-send.** Pull `reset_n` low after byte 2 of a packet while 3 packets are queued. Required: no further bytes, `count` = 0, and the next pushed packet is sent intact from byte 0.
